direction_arbiter: RTL and testbench

- Sits between the IR remote decoder, the board pushbuttons and the VGA sprite renderer.
- Shares the single sprite-position register between two direction sources: IR commands and pushbuttons.
- Arbitrates between the sources, holds each IR command for a fixed number of frames, and applies one bounded step per frame.
- PosX/PosY feed the pixel generator directly.

---
 rtl/direction_arbiter.sv | 156 +++++++++++++++
 tb/tb_direction_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/direction_arbiter.sv
// Purpose: arbitrate IR and pushbutton direction sources onto one clamped sprite position.
// Latency: position, Moving and Source update on the clock edge that samples FrameTick; they are visible one cycle later.
// Backpressure: none; IR pulses and frame ticks are consumed on arrival and never stalled.
module direction_arbiter #(
    parameter int X_W         = 10,
    parameter int Y_W         = 10,
    parameter int X_MAX       = 639,
    parameter int Y_MAX       = 479,
    parameter int X_INIT      = 320,
    parameter int Y_INIT      = 240,
    parameter int STEP        = 4,
    parameter int HOLD_FRAMES = 8
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           IrUp,
    input  logic           IrDown,
    input  logic           IrLeft,
    input  logic           IrRight,
    input  logic           IrReadable,
    input  logic           BtnUp,
    input  logic           BtnDown,
    input  logic           BtnLeft,
    input  logic           BtnRight,
    input  logic           FrameTick,
    output logic [X_W-1:0] PosX,
    output logic [Y_W-1:0] PosY,
    output logic           Moving,
    output logic           Source
);

    typedef enum logic [1:0] {S_IDLE, S_BTN, S_IR} state_t;
    typedef enum logic [2:0] {DIR_NONE, DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    localparam logic [X_W-1:0] X_STEP  = X_W'(STEP);
    localparam logic [X_W-1:0] X_LIM   = X_W'(X_MAX - STEP);
    localparam logic [X_W-1:0] X_TOP   = X_W'(X_MAX);
    localparam logic [X_W-1:0] X_START = X_W'(X_INIT);
    localparam logic [Y_W-1:0] Y_STEP  = Y_W'(STEP);
    localparam logic [Y_W-1:0] Y_LIM   = Y_W'(Y_MAX - STEP);
    localparam logic [Y_W-1:0] Y_TOP   = Y_W'(Y_MAX);
    localparam logic [Y_W-1:0] Y_START = Y_W'(Y_INIT);
    localparam logic [7:0]     HOLD    = 8'(HOLD_FRAMES);

    state_t         state;
    state_t         state_nxt;
    dir_t           ir_cmd;
    dir_t           ir_new;
    dir_t           btn_dir;
    dir_t           eff_cmd;
    dir_t           move_dir;
    logic [7:0]     hold_cnt;
    logic [7:0]     eff_cnt;
    logic [7:0]     hold_nxt;
    logic           ir_cap;
    logic           moving_nxt;
    logic           source_nxt;
    logic [X_W-1:0] pos_x_nxt;
    logic [Y_W-1:0] pos_y_nxt;

    // A direction is only meaningful when exactly one line is high.
    function automatic dir_t decode_dir(input logic [3:0] lines);
        case (lines)
            4'b1000: decode_dir = DIR_UP;
            4'b0100: decode_dir = DIR_DOWN;
            4'b0010: decode_dir = DIR_LEFT;
            4'b0001: decode_dir = DIR_RIGHT;
            default: decode_dir = DIR_NONE;
        endcase
    endfunction

    // Decode both sources; a capture takes effect before the same cycle's tick decision.
    always_comb begin
        ir_new  = decode_dir({IrUp, IrDown, IrLeft, IrRight});
        btn_dir = decode_dir({BtnUp, BtnDown, BtnLeft, BtnRight});
        ir_cap  = IrReadable && (ir_new != DIR_NONE);
        eff_cmd = ir_cap ? ir_new : ir_cmd;
        eff_cnt = ir_cap ? HOLD : hold_cnt;
    end

    // State decision on FrameTick only: buttons win, then a live IR hold, else idle.
    always_comb begin
        state_nxt  = state;
        moving_nxt = Moving;
        source_nxt = Source;
        move_dir   = DIR_NONE;
        if (FrameTick) begin
            if (btn_dir != DIR_NONE) begin
                state_nxt  = S_BTN;
                moving_nxt = 1'b1;
                source_nxt = 1'b1;
                move_dir   = btn_dir;
            end else if (eff_cnt != 8'd0) begin
                state_nxt  = S_IR;
                moving_nxt = 1'b1;
                source_nxt = 1'b0;
                move_dir   = eff_cmd;
            end else begin
                state_nxt  = S_IDLE;
                moving_nxt = 1'b0;
            end
        end
    end

    // Hold counter: reload wins; it only drains on ticks where IR actually drives motion.
    always_comb begin
        hold_nxt = hold_cnt;
        if (ir_cap) begin
            hold_nxt = HOLD;
        end else if (FrameTick && (state_nxt == S_IR) && (hold_cnt != 8'd0)) begin
            hold_nxt = hold_cnt - 8'd1;
        end
    end

    // One clamped step toward the chosen direction; compare before subtracting to avoid wrap.
    always_comb begin
        pos_x_nxt = PosX;
        pos_y_nxt = PosY;
        case (move_dir)
            DIR_LEFT:  pos_x_nxt = (PosX < X_STEP) ? '0 : PosX - X_STEP;
            DIR_RIGHT: pos_x_nxt = (PosX > X_LIM) ? X_TOP : PosX + X_STEP;
            DIR_UP:    pos_y_nxt = (PosY < Y_STEP) ? '0 : PosY - Y_STEP;
            DIR_DOWN:  pos_y_nxt = (PosY > Y_LIM) ? Y_TOP : PosY + Y_STEP;
            default:   ;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Position, status flags and the IR command/hold registers.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            PosX     <= X_START;
            PosY     <= Y_START;
            Moving   <= 1'b0;
            Source   <= 1'b0;
            ir_cmd   <= DIR_NONE;
            hold_cnt <= 8'd0;
        end else begin
            PosX     <= pos_x_nxt;
            PosY     <= pos_y_nxt;
            Moving   <= moving_nxt;
            Source   <= source_nxt;
            ir_cmd   <= eff_cmd;
            hold_cnt <= hold_nxt;
        end
    end

endmodule

// File: tb/tb_direction_arbiter.sv
// Purpose: directed, table-driven check of direction_arbiter with default parameters.
// Latency: each vector is driven for one clock; outputs are sampled 1 time unit after the edge.
// Backpressure: not applicable; the bench drives every input directly.
module tb_direction_arbiter;

    logic       Clock;
    logic       Reset;
    logic       IrUp, IrDown, IrLeft, IrRight, IrReadable;
    logic       BtnUp, BtnDown, BtnLeft, BtnRight;
    logic       FrameTick;
    logic [9:0] PosX;
    logic [9:0] PosY;
    logic       Moving;
    logic       Source;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [3:0] ir;    // {Up, Down, Left, Right}
        logic       ird;
        logic [3:0] btn;   // {Up, Down, Left, Right}
        logic       tick;
        int         x;
        int         y;
        logic       mv;
        logic       src;
    } vec_t;

    vec_t vecs[$];

    localparam logic [3:0] N = 4'b0000;
    localparam logic [3:0] U = 4'b1000;
    localparam logic [3:0] D = 4'b0100;
    localparam logic [3:0] L = 4'b0010;
    localparam logic [3:0] R = 4'b0001;

    direction_arbiter dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .IrUp      (IrUp),
        .IrDown    (IrDown),
        .IrLeft    (IrLeft),
        .IrRight   (IrRight),
        .IrReadable(IrReadable),
        .BtnUp     (BtnUp),
        .BtnDown   (BtnDown),
        .BtnLeft   (BtnLeft),
        .BtnRight  (BtnRight),
        .FrameTick (FrameTick),
        .PosX      (PosX),
        .PosY      (PosY),
        .Moving    (Moving),
        .Source    (Source)
    );

    always #5 Clock = ~Clock;

    task automatic add(input logic [3:0] ir, input logic ird, input logic [3:0] btn,
                       input logic tick, input int x, input int y, input logic mv, input logic src);
        vec_t v;
        v.ir = ir; v.ird = ird; v.btn = btn; v.tick = tick;
        v.x = x; v.y = y; v.mv = mv; v.src = src;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int idx, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input int idx, input int x, input int y,
                             input logic mv, input logic src);
        check({tag, ".PosX"},   idx, int'(PosX),   x);
        check({tag, ".PosY"},   idx, int'(PosY),   y);
        check({tag, ".Moving"}, idx, int'(Moving), int'(mv));
        check({tag, ".Source"}, idx, int'(Source), int'(src));
    endtask

    task automatic drive(input logic [3:0] ir, input logic ird, input logic [3:0] btn, input logic tick);
        {IrUp, IrDown, IrLeft, IrRight}     = ir;
        IrReadable                          = ird;
        {BtnUp, BtnDown, BtnLeft, BtnRight} = btn;
        FrameTick                           = tick;
    endtask

    initial begin
        int ex;
        int ey;
        n_cmp = 0;
        n_bad = 0;
        Clock = 1'b0;
        Reset = 1'b1;
        drive(N, 1'b0, N, 1'b0);

        // ---- vector table ----
        add(N, 0, N, 1, 320, 240, 0, 0);                      // idle tick, no motion
        add(R, 1, N, 0, 320, 240, 0, 0);                      // capture Right, no tick yet
        for (int i = 1; i <= 10; i++)                         // 8 moves then hold expires
            add(N, 0, N, 1, (i <= 8) ? 320 + 4 * i : 352, 240, (i <= 8), 0);
        add(L, 1, N, 0, 352, 240, 0, 0);                      // capture Left
        for (int i = 1; i <= 3; i++)                          // buttons override IR
            add(N, 0, U, 1, 352, 240 - 4 * i, 1, 1);
        add(N, 0, N, 1, 348, 228, 1, 0);                      // IR resumes, hold 8 -> 7
        add(U | L, 1, N, 0, 348, 228, 1, 0);                  // two IR bits: ignored
        add(N, 1, N, 0, 348, 228, 1, 0);                      // no IR bits: ignored
        for (int i = 1; i <= 7; i++)                          // exactly 7 frames left
            add(N, 0, N, 1, 348 - 4 * i, 228, 1, 0);
        add(N, 0, N, 1, 320, 228, 0, 0);                      // expired
        add(N, 0, U | R, 1, 320, 228, 0, 0);                  // two buttons: no ownership
        add(R, 1, N, 0, 320, 228, 0, 0);
        add(N, 0, U | R, 1, 324, 228, 1, 0);                  // two buttons lose to IR, hold 7
        ex = 324;
        while (ex != 639) begin                               // buttons to right edge
            ex = (ex > 635) ? 639 : ex + 4;
            add(N, 0, R, 1, ex, 228, 1, 1);
        end
        add(N, 0, R, 1, 639, 228, 1, 1);                      // stays at X_MAX
        for (int i = 1; i <= 7; i++)                          // IR resumes with hold 7, clamped
            add(N, 0, N, 1, 639, 228, 1, 0);
        add(N, 0, N, 1, 639, 228, 0, 0);
        add(N, 0, L, 1, 635, 228, 1, 1);
        add(N, 0, N, 1, 635, 228, 0, 1);                      // idle keeps Source=1
        ex = 635;
        while (ex != 0) begin                                 // 635 .. 3 -> 0
            ex = (ex < 4) ? 0 : ex - 4;
            add(N, 0, L, 1, ex, 228, 1, 1);
        end
        add(N, 0, L, 1, 0, 228, 1, 1);
        ey = 228;
        while (ey != 0) begin
            ey = ey - 4;
            add(N, 0, U, 1, 0, ey, 1, 1);
        end
        add(N, 0, U, 1, 0, 0, 1, 1);
        while (ey != 479) begin                               // 0 .. 476 -> 479
            ey = (ey > 475) ? 479 : ey + 4;
            add(N, 0, D, 1, 0, ey, 1, 1);
        end
        add(N, 0, D, 1, 0, 479, 1, 1);
        for (int i = 1; i <= 10; i++) add(N, 0, U, 1, 0, 479 - 4 * i, 1, 1);
        for (int i = 1; i <= 10; i++) add(N, 0, R, 1, 4 * i, 439, 1, 1);
        add(L, 1, N, 0, 40, 439, 1, 1);                       // capture between ticks
        add(N, 0, N, 1, 36, 439, 1, 0);                       // hold 7
        add(N, 0, N, 1, 32, 439, 1, 0);                       // hold 6
        add(D, 1, N, 1, 32, 443, 1, 0);                       // coincident: Down now, hold 8
        for (int i = 1; i <= 8; i++) add(N, 0, N, 1, 32, 443 + 4 * i, 1, 0);
        add(N, 0, N, 1, 32, 475, 0, 0);

        // ---- reset state ----
        #12;
        check_all("reset", 0, 320, 240, 1'b0, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;

        // ---- apply table ----
        foreach (vecs[k]) begin
            drive(vecs[k].ir, vecs[k].ird, vecs[k].btn, vecs[k].tick);
            @(posedge Clock);
            #1;
            check_all("vec", k + 1, vecs[k].x, vecs[k].y, vecs[k].mv, vecs[k].src);
        end

        // ---- asynchronous reset mid-move ----
        drive(R, 1'b1, N, 1'b0);
        @(posedge Clock);
        #1;
        drive(N, 1'b0, N, 1'b1);
        @(posedge Clock);
        #1;
        check_all("pre_rst", 1, 36, 475, 1'b1, 1'b0);
        drive(N, 1'b0, N, 1'b0);
        #2;
        Reset = 1'b1;
        #1;
        check_all("async_rst", 1, 320, 240, 1'b0, 1'b0);
        @(negedge Clock);
        Reset = 1'b0;
        for (int i = 1; i <= 2; i++) begin                    // pending command was discarded
            drive(N, 1'b0, N, 1'b1);
            @(posedge Clock);
            #1;
            check_all("post_rst", i, 320, 240, 1'b0, 1'b0);
        end
        drive(N, 1'b0, N, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
